dcache_l2_bridge: RTL



---
 rtl/dl2_pkg.sv | 12 +
 rtl/dcache_l2_bridge_if.sv | 23 ++
 rtl/dl2_line_serdes.sv | 31 +++
 rtl/dcache_l2_bridge.sv | 113 +++++++++++
 4 files changed

// File: rtl/dl2_pkg.sv
// dl2_pkg: shared types, defaults and address helper for the dcache L2 bridge
package dl2_pkg;
  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 32;
  localparam int BLOCK_SIZE    = 32;
  typedef enum logic [2:0] {IDLE, WB_REQ, WB_DONE, RD_REQ, RD_WAIT, FILL_RSP} state_t;
  // Byte address of one beat: line address above the line offset, beat index above the word offset.
  function automatic logic [63:0] beat_addr(input logic [63:0] line_addr, input logic [63:0] beat,
                                            input int off_w, input int word_sh);
    return (line_addr << off_w) | (beat << word_sh);
  endfunction
endpackage

// File: rtl/dcache_l2_bridge_if.sv
// dcache_l2_bridge_if: word-wide memory bus between the bridge (master) and memory (slave)
interface dcache_l2_bridge_if
  import dl2_pkg::*;
#(
  parameter int data_width    = DATA_WIDTH,
  parameter int address_width = ADDRESS_WIDTH
);
  logic                     MEM_REQ_VALID;
  logic                     MEM_REQ_READY;
  logic                     MEM_REQ_WE;
  logic [address_width-1:0] MEM_REQ_ADDR;
  logic [data_width-1:0]    MEM_REQ_WDATA;
  logic                     MEM_RDATA_VALID;
  logic [data_width-1:0]    MEM_RDATA;
  modport master (
    output MEM_REQ_VALID, MEM_REQ_WE, MEM_REQ_ADDR, MEM_REQ_WDATA,
    input  MEM_REQ_READY, MEM_RDATA_VALID, MEM_RDATA
  );
  modport slave (
    input  MEM_REQ_VALID, MEM_REQ_WE, MEM_REQ_ADDR, MEM_REQ_WDATA,
    output MEM_REQ_READY, MEM_RDATA_VALID, MEM_RDATA
  );
endinterface

// File: rtl/dl2_line_serdes.sv
// dl2_line_serdes: line register with beat counter; loads a whole line, selects or inserts one word per beat
module dl2_line_serdes
  import dl2_pkg::*;
#(
  parameter int data_width  = DATA_WIDTH,
  parameter int block_size  = BLOCK_SIZE,
  localparam int cache_width = block_size * data_width,
  localparam int beat_width  = $clog2(block_size)
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   load,
  input  logic [cache_width-1:0] line_in,
  input  logic                   step,
  input  logic                   put,
  input  logic [data_width-1:0]  word_in,
  output logic [beat_width-1:0]  beat,
  output logic [data_width-1:0]  word_out,
  output logic [cache_width-1:0] line_q
);
  // Beat counter wraps naturally after the last word, so every line starts at beat 0.
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) beat <= '0;
    else if (step) beat <= beat + 1'b1;
  // Whole-line load for writebacks, single-word insert for fills.
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) line_q <= '0;
    else if (load) line_q <= line_in;
    else if (put) line_q[beat*data_width +: data_width] <= word_in;
  assign word_out = line_q[beat*data_width +: data_width];
endmodule

// File: rtl/dcache_l2_bridge.sv
// dcache_l2_bridge: serializes dcache line fills/writebacks onto a word-wide memory bus; define DL2_PERF_CNT_EN for perf counters
module dcache_l2_bridge
  import dl2_pkg::*;
#(
  parameter int data_width     = DATA_WIDTH,
  parameter int address_width  = ADDRESS_WIDTH,
  parameter int block_size     = BLOCK_SIZE,
  localparam int offset_width  = $clog2(data_width * block_size / 8),
  localparam int cache_width   = block_size * data_width,
  localparam int beat_width    = $clog2(block_size),
  localparam int line_width    = address_width - offset_width,
  localparam int word_shift    = $clog2(data_width / 8)
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   ADDR_TO_L2_VALID,
  input  logic [line_width-1:0]  ADDR_TO_L2,
  input  logic                   DATA_TO_L2_VALID,
  input  logic [cache_width-1:0] DATA_TO_L2,
  input  logic [line_width-1:0]  WADDR_TO_L2,
  output logic [cache_width-1:0] DATA_FROM_L2,
  output logic                   DATA_FROM_L2_VALID,
  output logic                   WRITE_DONE,
  dcache_l2_bridge_if.master     mem
`ifdef DL2_PERF_CNT_EN
  ,
  output logic [31:0]            PERF_FILLS,
  output logic [31:0]            PERF_WBS,
  output logic [31:0]            PERF_STALLS
`endif
);
  localparam logic [beat_width-1:0] last_beat = beat_width'(block_size - 1);
  state_t                 state, state_n;
  logic                   fill_pend, wb_pend, fill_cap, wb_cap, req_ok, rsp_ok, in_wb, in_rd;
  logic [line_width-1:0]  fill_addr, wb_addr;
  logic [beat_width-1:0]  req_beat, wb_beat, rsp_beat;
  logic [data_width-1:0]  wb_word, fill_word_unused;
  logic [cache_width-1:0] wb_line_unused;
  assign in_wb    = state == WB_REQ || state == WB_DONE;
  assign in_rd    = state == RD_REQ || state == RD_WAIT;
  assign fill_cap = ADDR_TO_L2_VALID && !fill_pend;
  assign wb_cap   = DATA_TO_L2_VALID && !wb_pend && !in_wb;
  assign req_ok   = mem.MEM_REQ_VALID && mem.MEM_REQ_READY;
  assign rsp_ok   = mem.MEM_RDATA_VALID && in_rd;
  dl2_line_serdes #(.data_width(data_width), .block_size(block_size)) u_wb (
    .CLK(CLK), .RSTN(RSTN), .load(wb_cap), .line_in(DATA_TO_L2),
    .step(state == WB_REQ && req_ok), .put(1'b0), .word_in('0),
    .beat(wb_beat), .word_out(wb_word), .line_q(wb_line_unused)
  );
  dl2_line_serdes #(.data_width(data_width), .block_size(block_size)) u_fill (
    .CLK(CLK), .RSTN(RSTN), .load(1'b0), .line_in('0),
    .step(rsp_ok), .put(rsp_ok), .word_in(mem.MEM_RDATA),
    .beat(rsp_beat), .word_out(fill_word_unused), .line_q(DATA_FROM_L2)
  );
  // Request capture: a pending slot holds one fill and one writeback; held writeback valids are ignored until done.
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      fill_pend <= 1'b0;
      wb_pend   <= 1'b0;
      fill_addr <= '0;
      wb_addr   <= '0;
    end else begin
      if (fill_cap) begin
        fill_pend <= 1'b1;
        fill_addr <= ADDR_TO_L2;
      end else if (state == FILL_RSP) fill_pend <= 1'b0;
      if (wb_cap) begin
        wb_pend <= 1'b1;
        wb_addr <= WADDR_TO_L2;
      end else if (state == WB_DONE) wb_pend <= 1'b0;
    end
  // Read request beat counter; responses are counted separately inside the fill serdes.
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) req_beat <= '0;
    else if (state == RD_REQ && req_ok) req_beat <= req_beat + 1'b1;
  // State register.
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) state <= IDLE;
    else state <= state_n;
  // Next state: writebacks win over fills; a request captured this cycle dispatches immediately.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     state_n = (wb_pend || wb_cap) ? WB_REQ : (fill_pend || fill_cap) ? RD_REQ : IDLE;
      WB_REQ:   state_n = (req_ok && wb_beat == last_beat) ? WB_DONE : WB_REQ;
      WB_DONE:  state_n = IDLE;
      RD_REQ:   state_n = (req_ok && req_beat == last_beat) ? RD_WAIT : RD_REQ;
      RD_WAIT:  state_n = (rsp_ok && rsp_beat == last_beat) ? FILL_RSP : RD_WAIT;
      FILL_RSP: state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  assign mem.MEM_REQ_VALID  = state == WB_REQ || state == RD_REQ;
  assign mem.MEM_REQ_WE     = state == WB_REQ;
  assign mem.MEM_REQ_ADDR   = state == WB_REQ ? address_width'(beat_addr(64'(wb_addr), 64'(wb_beat), offset_width, word_shift)) :
                              state == RD_REQ ? address_width'(beat_addr(64'(fill_addr), 64'(req_beat), offset_width, word_shift)) : '0;
  assign mem.MEM_REQ_WDATA  = state == WB_REQ ? wb_word : '0;
  assign DATA_FROM_L2_VALID = state == FILL_RSP;
  assign WRITE_DONE         = state == WB_DONE;
`ifdef DL2_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      PERF_FILLS  <= '0;
      PERF_WBS    <= '0;
      PERF_STALLS <= '0;
    end else begin
      if (DATA_FROM_L2_VALID && !(&PERF_FILLS)) PERF_FILLS <= PERF_FILLS + 32'd1;
      if (WRITE_DONE && !(&PERF_WBS)) PERF_WBS <= PERF_WBS + 32'd1;
      if (mem.MEM_REQ_VALID && !mem.MEM_REQ_READY && !(&PERF_STALLS)) PERF_STALLS <= PERF_STALLS + 32'd1;
    end
`endif
endmodule
